// File: rtl/mbist_sequencer_if.sv
// mbist_sequencer_if: test-access and engine-side signals of the MBIST sequencer.
// slave = sequencer, master = test-access port plus algorithm engines.
interface mbist_sequencer_if #(
  parameter int NUM_ALG = 3,
  parameter int SEL_W   = 3
) ();
  logic               test_mode;
  logic [SEL_W-1:0]   operation;
  logic               run_all;
  logic [NUM_ALG-1:0] alg_complete;
  logic [NUM_ALG-1:0] alg_fail;
  logic [NUM_ALG-1:0] alg_en;
  logic               busy;
  logic               complete;
  logic [NUM_ALG-1:0] fail_map;
  logic               timeout;
  modport slave (
    input  test_mode, operation, run_all, alg_complete, alg_fail,
    output alg_en, busy, complete, fail_map, timeout
  );
  modport master (
    output test_mode, operation, run_all, alg_complete, alg_fail,
    input  alg_en, busy, complete, fail_map, timeout
  );
endinterface

// File: rtl/mbist_sequencer.sv
// mbist_sequencer: runs one or all MBIST algorithm engines and collects a pass/fail map.
// Define MBIST_TIMEOUT_EN to add a per-algorithm watchdog of TIMEOUT_W bits.
module mbist_sequencer #(
  parameter int NUM_ALG   = 3,
  parameter int SEL_W     = 3,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  mbist_sequencer_if.slave  bus
);
  localparam int IDX_W = NUM_ALG > 1 ? $clog2(NUM_ALG) : 1;
  if (NUM_ALG < 1 || NUM_ALG > 8 || TIMEOUT_W < 2) begin : g_bad_param
    $error("mbist_sequencer: NUM_ALG must be 1..8 and TIMEOUT_W at least 2");
  end
  typedef enum logic [2:0] {IDLE, SETUP, RUN, GAP, DONE} state_t;
  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             all_q;
  logic             done_hit, expire, ev, adv;
`ifdef MBIST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  // Held at zero outside RUN, so every entry to RUN starts a fresh count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= state == RUN ? cnt + TIMEOUT_W'(1) : '0;
`endif
  always_comb begin
    done_hit = state == RUN && bus.alg_complete[idx];
`ifdef MBIST_TIMEOUT_EN
    expire = state == RUN && &cnt && !done_hit;
`else
    expire = 1'b0;
`endif
    ev = done_hit || expire;
    adv = all_q && 32'(idx) < NUM_ALG - 1;
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: state_n = bus.test_mode ? SETUP : IDLE;
      SETUP: begin
        state_n = bus.test_mode ? RUN : IDLE;
        idx_n = bus.run_all || 32'(bus.operation) >= NUM_ALG ? '0 : IDX_W'(bus.operation);
      end
      RUN: begin
        state_n = !bus.test_mode ? IDLE : !ev ? RUN : adv ? GAP : DONE;
        if (bus.test_mode && ev && adv) idx_n = idx + IDX_W'(1);
      end
      GAP: state_n = bus.test_mode ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      all_q        <= 1'b0;
      bus.alg_en   <= '0;
      bus.busy     <= 1'b0;
      bus.complete <= 1'b0;
      bus.fail_map <= '0;
      bus.timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      bus.alg_en   <= state_n == RUN ? NUM_ALG'(1) << idx_n : '0;
      bus.busy     <= state_n != IDLE;
      bus.complete <= state_n == DONE;
      if (state == SETUP) all_q <= bus.run_all;
      if (state == IDLE && bus.test_mode) begin
        bus.fail_map <= '0;
        bus.timeout  <= 1'b0;
      end else if (done_hit) bus.fail_map[idx] <= bus.alg_fail[idx];
      else if (expire) begin
        bus.fail_map[idx] <= 1'b1;
        bus.timeout       <= 1'b1;
      end
    end
endmodule
